serial_add_sequencer: RTL and testbench
=======================================

# serial_add_sequencer

Word-level front/back end for the team's bit-serial full-adder cell (full adder plus carry flip-flop). Loads two WIDTH-bit parallel operands, feeds them to the cell LSB-first one bit per clock, collects the returned serial sum bits into a parallel result and captures the final carry. Provides a start/busy/done handshake so a parallel datapath can use the serial adder as a multi-cycle functional unit.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clock  input  1  rising-edge clock, shared with the adder cell
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured on the accepting edge
- op_b  input  WIDTH  operand B, captured on the accepting edge
- a_bit  output  1  serial A bit to the adder cell
- b_bit  output  1  serial B bit to the adder cell
- adder_reset  output  1  active-low carry clear to the adder cell
- sum_bit  input  1  serial sum from the adder cell (combinational)
- c_in_bit  input  1  carry-out from the adder cell (combinational)
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  parallel sum
- carry  output  1  final carry-out of the word add

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: start=1 → load op_a/op_b into shift registers, bit counter=0, next SHIFT. start=0 → stay.
- SHIFT: a_bit=a_sr[0], b_bit=b_sr[0]. Each edge: shift sum_bit into result register at MSB (right shift), shift a_sr/b_sr right, counter+1. On the edge with counter=WIDTH-1: capture c_in_bit into carry, next DONE.
- DONE: done=1 for exactly one cycle, next IDLE unconditionally.
- adder_reset = 0 in IDLE and DONE, 1 only in SHIFT. Carry for bit 0 is therefore 0.
- a_bit/b_bit = 0 outside SHIFT.
- result and carry hold their last values in IDLE until the next accepted start. They are overwritten during SHIFT and are valid only from done onward.
- start during SHIFT or DONE is ignored and not queued.
- Arithmetic: result = (op_a + op_b) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum. No signed overflow flag.
- Counter width is clog2(WIDTH). No wrap beyond WIDTH-1.

## Timing
- Edge 0: start accepted in IDLE.
- Cycles 1..WIDTH (after edges 0..WIDTH-1): busy=1, bit i presented in cycle i+1.
- Edge WIDTH: last sum bit and carry captured.
- Cycle WIDTH+1: done=1, busy=0.
- Latency start-edge→done = WIDTH cycles. Next start accepted at the edge ending the cycle after done (the IDLE cycle). Throughput is one add per WIDTH+2 cycles.
- start held continuously re-triggers each time IDLE is reached.
- reset low at any time, including mid-SHIFT:
  - outputs change immediately, without waiting for a clock edge: state=IDLE, busy=0, done=0, result=0, carry=0, a_bit=b_bit=0, adder_reset=0.
  - The partial operation is discarded.
- Reset values: busy=0, done=0, result=0, carry=0, a_bit=0, b_bit=0, adder_reset=0.

## Test plan
Bench: WIDTH=8, DUT wired to the bit-serial full-adder cell.
- op_a=0x35, op_b=0x4A, start pulse → done 8 cycles later, result=0x7F, carry=0; busy high exactly 8 cycles.
- op_a=0xFF, op_b=0x01 → result=0x00, carry=1 (full carry ripple). Then 0x80+0x80 → result=0x00, carry=1. Then 0x00+0x00 → result=0x00, carry=0, proving carry is cleared between words.
- start held high with operands 0x12/0x34, then 0x56/0x78 → done pulses 10 cycles apart; results 0x46 then 0xCE, carry 0 both.
- start pulsed mid-SHIFT with different operands → ignored; result matches the first operands only; no extra done.
- reset driven low at bit 4 of 0xAA+0x55 → outputs reset immediately. After release, 0x0F+0x01 → result=0x10, carry=0.
- Idle for 20 cycles after done → result/carry stable, done stays 0, a_bit=b_bit=0.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: word-level front/back end for a bit-serial adder cell.
//
// Ports:
//   clk_i          rising-edge clock, shared with the adder cell
//   rst_ni         asynchronous active-low reset
//   start_i        add request, sampled only in IDLE
//   op_a_i/op_b_i  WIDTH-bit operands, captured on the accepting edge
//   a_bit_o/b_bit_o  serial operand bits to the cell, LSB first
//   adder_reset_o  active-low carry clear to the cell
//   sum_bit_i      serial sum from the cell
//   c_in_bit_i     carry-out from the cell
//   busy_o         high while bits are being shifted
//   done_o         one-cycle pulse, result_o/carry_o valid
//   result_o       parallel sum
//   carry_o        final carry-out of the word add
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             a_bit_o,
    output logic             b_bit_o,
    output logic             adder_reset_o,
    input  logic             sum_bit_i,
    input  logic             c_in_bit_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_sr_d  = op_a_i;
                    b_sr_d  = op_b_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits arrive LSB first, so they enter at the MSB
                // and walk down to their final position.
                res_d  = {sum_bit_i, res_q[WIDTH-1:1]};
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                if (cnt_q == LAST) begin
                    carry_d = c_in_bit_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q == SHIFT);
    assign done_o        = (state_q == DONE);
    // Cell carry is held clear except while a word is in flight,
    // so bit 0 always sees carry-in 0.
    assign adder_reset_o = busy_o;
    assign a_bit_o       = busy_o & a_sr_q[0];
    assign b_bit_o       = busy_o & b_sr_q[0];
    assign result_o      = res_q;
    assign carry_o       = carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: sequencer wired to a bit-serial full-adder cell,
// random and directed adds checked by a queue-based scoreboard.
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         a_bit;
    logic         b_bit;
    logic         adder_reset;
    logic         sum_bit;
    logic         c_in_bit;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .a_bit_o      (a_bit),
        .b_bit_o      (b_bit),
        .adder_reset_o(adder_reset),
        .sum_bit_i    (sum_bit),
        .c_in_bit_i   (c_in_bit),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .carry_o      (carry)
    );

    // Bit-serial full-adder cell: full adder plus carry flip-flop.
    logic cell_c;
    assign sum_bit  = a_bit ^ b_bit ^ cell_c;
    assign c_in_bit = (a_bit & b_bit) | (a_bit & cell_c) | (b_bit & cell_c);
    always @(posedge clk or negedge adder_reset) begin
        if (!adder_reset) cell_c <= 1'b0;
        else              cell_c <= c_in_bit;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
    } exp_t;

    exp_t         sb_q[$];
    int           n_total = 0;
    int           n_pass  = 0;
    int           dones   = 0;

    // Reference model: an accepted add occupies W shift cycles plus one
    // done cycle; "left" counts the cycles still to go.
    int           left = 0;
    logic [W-1:0] cur_a = '0;
    logic [W-1:0] cur_b = '0;
    logic [W-1:0] cur_res = '0;
    logic         cur_c = 1'b0;
    logic [W-1:0] last_res = '0;
    logic         last_c = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left     <= 0;
            last_res <= '0;
            last_c   <= 1'b0;
            sb_q.delete();
        end else if (left == 0) begin
            if (start) begin
                logic [W:0] s;
                s = {1'b0, op_a} + {1'b0, op_b};
                cur_a   <= op_a;
                cur_b   <= op_b;
                cur_res <= s[W-1:0];
                cur_c   <= s[W];
                sb_q.push_back('{res: s[W-1:0], c: s[W]});
                left    <= W + 1;
            end
        end else begin
            if (left == 1) begin
                last_res <= cur_res;
                last_c   <= cur_c;
            end
            left <= left - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h @%0t",
                      name, act, exp, $time);
    endtask

    // Monitor: per-cycle protocol checks plus scoreboard pop on done.
    always @(negedge clk) begin
        int idx;
        exp_t e;
        if (left >= 2) begin
            idx = W + 1 - left;
            chk("busy", 32'(busy), 32'd1);
            chk("adder_reset", 32'(adder_reset), 32'd1);
            chk("a_bit", 32'(a_bit), 32'(cur_a[idx]));
            chk("b_bit", 32'(b_bit), 32'(cur_b[idx]));
        end else begin
            chk("busy", 32'(busy), 32'd0);
            chk("adder_reset", 32'(adder_reset), 32'd0);
            chk("a_bit_idle", 32'(a_bit), 32'd0);
            chk("b_bit_idle", 32'(b_bit), 32'd0);
        end
        chk("done", 32'(done), 32'(left == 1));
        if (left == 0) begin
            chk("result_hold", 32'(result), 32'(last_res));
            chk("carry_hold", 32'(carry), 32'(last_c));
        end
        if (done === 1'b1) begin
            dones++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("carry", 32'(carry), 32'(e.c));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (left != 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (left != 0) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (left != W + 1 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (left != W + 1) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #2;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk); #2;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        wait_idle();
        @(posedge clk); #2;
    endtask

    initial begin
        int d0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        do_op(8'h35, 8'h4A);
        do_op(8'hFF, 8'h01);
        do_op(8'h80, 8'h80);
        do_op(8'h00, 8'h00);

        // Held start: back-to-back adds, done pulses W+2 cycles apart.
        @(posedge clk); #2;
        start = 1'b1;
        op_a  = 8'h12;
        op_b  = 8'h34;
        wait_accept();
        op_a  = 8'h56;
        op_b  = 8'h78;
        d0 = dones;
        repeat (W + 2) @(posedge clk);
        #2;
        chk("held_retrigger", 32'(left), 32'(W + 1));
        chk("held_done_count", 32'(dones - d0), 32'd1);
        start = 1'b0;
        wait_idle();

        // Start pulsed mid-shift with other operands must be ignored.
        @(posedge clk); #2;
        start = 1'b1; op_a = 8'h11; op_b = 8'h22;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1; op_a = 8'hF0; op_b = 8'hF0;
        @(posedge clk); #2;
        start = 1'b0;
        d0 = dones;
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        chk("ignored_start_done", 32'(dones - d0), 32'd1);
        chk("ignored_start_res", 32'(result), 32'h33);

        // Asynchronous reset at bit 4 of 0xAA+0x55.
        @(posedge clk); #2;
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_carry", 32'(carry), 32'd0);
        chk("mid_rst_abit", 32'(a_bit), 32'd0);
        chk("mid_rst_bbit", 32'(b_bit), 32'd0);
        chk("mid_rst_adrst", 32'(adder_reset), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        do_op(8'h0F, 8'h01);

        repeat (20) @(posedge clk);

        // Random adds with random gaps and random ignored start pulses.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) != 0);
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                op_a = 8'hFF;
                op_b = W'($urandom_range(1, 255));
            end
            repeat ($urandom_range(1, 12)) @(posedge clk);
            #2;
            start = 1'b0;
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
